fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of decode_stage.
- Owns the PC register and the instruction-memory request handshake. Also owns the IF/ID pipeline register, whose outputs feed i_instr_d / i_pc_d / i_pc4_d of decode_stage.
- Handles branch/jump redirects from the execute stage, hazard-unit stalls and flushes, and variable-latency instruction memory, with at most one request outstanding.

---
 rtl/fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem handshake, IF/ID register.
// Optional macro FETCH_PERF_EN adds IF/ID load and bubble counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pcsrc_e,
  input  logic [DATA_WIDTH-1:0] i_pc_target_e,
  input  logic                  i_stall,
  input  logic                  i_flush_d,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_valid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr_d,
  output logic [DATA_WIDTH-1:0] o_pc_d,
  output logic [DATA_WIDTH-1:0] o_pc4_d,
  output logic                  o_valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           o_fetch_cnt,
  output logic [31:0]           o_bubble_cnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(32'd4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc_f;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_hold_instr;
  logic [DATA_WIDTH-1:0] r_hold_pc;
  logic [DATA_WIDTH-1:0] r_instr_d;
  logic [DATA_WIDTH-1:0] r_pc_d;
  logic [DATA_WIDTH-1:0] r_pc4_d;
  logic                  r_valid_d;
  logic                  w_capture;
  logic                  w_load_ok;
  logic [DATA_WIDTH-1:0] w_load_instr;
  logic [DATA_WIDTH-1:0] w_load_pc;
  logic                  w_ifid_load;
  logic                  w_ifid_bubble;

  // Request is dropped during reset so an abandoned transaction cannot complete.
  assign o_imem_req  = i_rst_n & (r_state != S_HOLD);
  assign o_imem_addr = r_req_addr;
  assign o_instr_d   = r_instr_d;
  assign o_pc_d      = r_pc_d;
  assign o_pc4_d     = r_pc4_d;
  assign o_valid_d   = r_valid_d;

  // Next-state and next-PC selection; redirect outranks stall outranks advance.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc_f;
    w_capture    = 1'b0;
    w_load_ok    = 1'b0;
    w_load_instr = r_hold_instr;
    w_load_pc    = r_hold_pc;
    case (r_state)
      S_FETCH: begin
        w_load_instr = i_imem_rdata;
        w_load_pc    = r_pc_f;
        if (i_pcsrc_e) begin
          w_pc_next    = i_pc_target_e;
          w_state_next = i_imem_valid ? S_FETCH : S_DRAIN;
        end else if (i_imem_valid) begin
          if (i_stall) begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_load_ok = 1'b1;
            w_pc_next = r_pc_f + PC_INC;
          end
        end else begin
          w_pc_next = r_pc_f;
        end
      end
      S_DRAIN: begin
        if (i_pcsrc_e) begin
          w_pc_next = i_pc_target_e;
        end else begin
          w_pc_next = r_pc_f;
        end
        if (i_imem_valid) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (i_pcsrc_e) begin
          w_pc_next    = i_pc_target_e;
          w_state_next = S_FETCH;
        end else if (!i_stall) begin
          w_load_ok    = 1'b1;
          w_pc_next    = r_hold_pc + PC_INC;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      default: begin
        w_state_next = S_FETCH;
        w_pc_next    = RESET_PC;
      end
    endcase
  end

  // IF/ID write selection: a redirect or flush forces a bubble, stall freezes, otherwise load.
  always_comb begin
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    if (i_pcsrc_e || i_flush_d) begin
      w_ifid_bubble = 1'b1;
    end else if (i_stall) begin
      w_ifid_bubble = 1'b0;
    end else if (w_load_ok) begin
      w_ifid_load = 1'b1;
    end else begin
      w_ifid_bubble = 1'b1;
    end
  end

  // PC, request address, hold buffer and IF/ID registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_FETCH;
      r_pc_f       <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc4_d      <= '0;
      r_valid_d    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc_f  <= w_pc_next;
      // The address is frozen outside FETCH so a pending response stays matched to it.
      if (w_state_next == S_FETCH) begin
        r_req_addr <= w_pc_next;
      end
      if (w_capture) begin
        r_hold_instr <= i_imem_rdata;
        r_hold_pc    <= r_pc_f;
      end
      if (w_ifid_bubble) begin
        r_instr_d <= NOP_INSTR;
        r_valid_d <= 1'b0;
      end else if (w_ifid_load) begin
        r_instr_d <= w_load_instr;
        r_pc_d    <= w_load_pc;
        r_pc4_d   <= w_load_pc + PC_INC;
        r_valid_d <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;

  // Performance counters for real and bubble IF/ID loads; both wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_ifid_load) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_ifid_bubble) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table with an IF/ID scoreboard queue.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcsrc;
  logic [31:0] target;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic        pcsrc;
    logic [31:0] target;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pcsrc_e     (pcsrc),
    .i_pc_target_e (target),
    .i_stall       (stall),
    .i_flush_d     (flush),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_valid  (imem_valid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_pc4_d       (pc4_d),
    .o_valid_d     (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic p, input logic [31:0] t,
                              input logic s, input logic f, input logic v,
                              input logic [31:0] d, input logic ereq,
                              input logic [31:0] eaddr, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [31:0] ep4,
                              input logic ev);
    vec_t x;
    x.rst_n = r; x.pcsrc = p; x.target = t; x.stall = s; x.flush = f;
    x.valid = v; x.rdata = d; x.exp_req = ereq; x.exp_addr = eaddr;
    x.exp_instr = ei; x.exp_pc = ep; x.exp_pc4 = ep4; x.exp_valid = ev;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle at negedge, check the request side, then check IF/ID after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; pcsrc = v.pcsrc; target = v.target; stall = v.stall;
    flush = v.flush; imem_valid = v.valid; imem_rdata = v.rdata;
    #1;
    chk("imem_req", idx, {31'd0, imem_req}, {31'd0, v.exp_req});
    chk("imem_addr", idx, imem_addr, v.exp_addr);
    e.instr = v.exp_instr; e.pc = v.exp_pc; e.pc4 = v.exp_pc4; e.valid = v.exp_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("instr_d", idx, instr_d, e.instr);
    chk("pc_d", idx, pc_d, e.pc);
    chk("pc4_d", idx, pc4_d, e.pc4);
    chk("valid_d", idx, {31'd0, valid_d}, {31'd0, e.valid});
  endtask

  initial begin
    rst_n = 1'b0; pcsrc = 1'b0; target = 32'd0; stall = 1'b0; flush = 1'b0;
    imem_valid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);

    //               rst  pc   target        st   fl   vld  rdata         req  addr          instr         pc            pc4           v
    vecs.push_back(mk(1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        NOP,          32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00500113, 1'b1,32'h0,        32'h00500113, 32'h0,        32'h4,        1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00C00193, 1'b1,32'h4,        32'h00C00193, 32'h4,        32'h8,        1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'hFF718393, 1'b1,32'h8,        32'hFF718393, 32'h8,        32'hC,        1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'h100,     1'b0,1'b0,1'b1,32'hDEAD0001, 1'b1,32'hC,        NOP,          32'h8,        32'hC,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,      NOP,          32'h8,        32'hC,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,      NOP,          32'h8,        32'hC,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00100093, 1'b1,32'h100,      32'h00100093, 32'h100,      32'h104,      1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'h40,      1'b0,1'b0,1'b0,32'h0,        1'b1,32'h104,      NOP,          32'h100,      32'h104,      1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'hBAD00BAD, 1'b1,32'h104,      NOP,          32'h100,      32'h104,      1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00208233, 1'b1,32'h40,       32'h00208233, 32'h40,       32'h44,       1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'h1C,      1'b0,1'b0,1'b1,32'hDEAD0002, 1'b1,32'h44,       NOP,          32'h40,       32'h44,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00000513, 1'b1,32'h1C,       32'h00000513, 32'h1C,       32'h20,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b1,1'b0,1'b1,32'h00312023, 1'b1,32'h20,       32'h00000513, 32'h1C,       32'h20,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b0,32'h20,       32'h00000513, 32'h1C,       32'h20,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,32'h20,       32'h00312023, 32'h20,       32'h24,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00A00593, 1'b1,32'h24,       32'h00A00593, 32'h24,       32'h28,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b1,1'b1,1'b0,32'h0,        1'b1,32'h28,       NOP,          32'h24,       32'h28,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00B00613, 1'b1,32'h28,       32'h00B00613, 32'h28,       32'h2C,       1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b1,1'b1,32'h11111111, 1'b1,32'h2C,       NOP,          32'h28,       32'h2C,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00C00693, 1'b1,32'h30,       32'h00C00693, 32'h30,       32'h34,       1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'hFFFFFFFC,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h34,       NOP,          32'h30,       32'h34,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'hBAD00BAD, 1'b1,32'h34,       NOP,          32'h30,       32'h34,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00000073, 1'b1,32'hFFFFFFFC, 32'h00000073, 32'hFFFFFFFC, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h00500113, 1'b1,32'h0,        32'h00500113, 32'h0,        32'h4,        1'b1));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b1,1'b0,1'b1,32'h22222222, 1'b1,32'h4,        32'h00500113, 32'h0,        32'h4,        1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'h80,      1'b1,1'b0,1'b0,32'h0,        1'b0,32'h4,        NOP,          32'h0,        32'h4,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h33333333, 1'b1,32'h80,       32'h33333333, 32'h80,       32'h84,       1'b1));
    vecs.push_back(mk(1'b1,1'b1,32'h200,     1'b0,1'b0,1'b0,32'h0,        1'b1,32'h84,       NOP,          32'h80,       32'h84,       1'b0));
    vecs.push_back(mk(1'b1,1'b1,32'h300,     1'b0,1'b0,1'b0,32'h0,        1'b1,32'h84,       NOP,          32'h80,       32'h84,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'hBAD00BAD, 1'b1,32'h84,       NOP,          32'h80,       32'h84,       1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h44444444, 1'b1,32'h300,      32'h44444444, 32'h300,      32'h304,      1'b1));
    vecs.push_back(mk(1'b0,1'b0,32'h0,       1'b0,1'b0,1'b1,32'hBAD00BAD, 1'b0,32'h304,      NOP,          32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h55555555, 1'b1,32'h0,        32'h55555555, 32'h0,        32'h4,        1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

`ifdef FETCH_PERF_EN
    // Counters restarted at the mid-request reset; one valid load since then.
    chk("fetch_cnt_after_reset", 100, fetch_cnt, 32'd1);
    chk("bubble_cnt_after_reset", 100, bubble_cnt, 32'd0);
    apply(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b1,32'h0000A001,1'b1,32'h4,32'h0000A001,32'h4,32'h8,1'b1), 101);
    apply(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b1,32'h0000A002,1'b1,32'h8,32'h0000A002,32'h8,32'hC,1'b1), 102);
    apply(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b1,32'h0000A003,1'b1,32'hC,32'h0000A003,32'hC,32'h10,1'b1), 103);
    chk("fetch_cnt_plus3", 103, fetch_cnt, 32'd4);
    apply(mk(1'b1,1'b1,32'h0,1'b0,1'b0,1'b1,32'h0000A004,1'b1,32'h10,NOP,32'hC,32'h10,1'b0), 104);
    chk("fetch_cnt_redirect", 104, fetch_cnt, 32'd4);
    chk("bubble_cnt_redirect", 104, bubble_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
